// File: rtl/fifo_sync_pkg.sv
// Shared types for the fifo_sync elastic buffer.
// FIFO_CHECK_EN (optional) sizes its sticky error counters from FIFO_DBG_CNT_W.
package fifo_sync_pkg;

  localparam int unsigned FIFO_DBG_CNT_W = 16;

  // Per-cycle queue operation, encoded as {accepted_write, accepted_read}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_sync_mem.sv
// Storage array for fifo_sync: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module fifo_sync_mem
  import fifo_sync_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_c
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_c = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync.sv
// First-word-fall-through synchronous FIFO used as the RAM-to-consumer elastic buffer.
// Optional macro FIFO_CHECK_EN adds simulation-only overflow/underflow reporting.
module fifo_sync
  import fifo_sync_pkg::*;
#(
  parameter int unsigned NUM_SLOTS     = 4,
  parameter int unsigned LOG_NUM_SLOTS = 2,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_write,
  input  logic                  write,
  output logic                  full,
  output logic                  almost_full,
  output logic [DATA_WIDTH-1:0] data_read,
  input  logic                  next_read,
  output logic                  empty
);

  localparam int unsigned PTR_W   = LOG_NUM_SLOTS;
  localparam int unsigned CNT_W   = LOG_NUM_SLOTS + 1;
  localparam int unsigned FULL_TH = NUM_SLOTS;
  localparam int unsigned AFULL_TH = NUM_SLOTS - 2;

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_en, rd_en;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  fifo_op_e              op;

  // Flags decode the registered occupancy only
  assign full        = (cnt_q == CNT_W'(FULL_TH));
  assign almost_full = (cnt_q >= CNT_W'(AFULL_TH));
  assign empty       = (cnt_q == '0);

  assign data_read = empty ? '0 : mem_rdata;

  // Write suppressed while in reset so a write there cannot corrupt storage
  assign mem_we = wr_en & rst;

  always_comb begin
    wr_en    = write & ~full;
    rd_en    = next_read & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    op       = fifo_op_e'({wr_en, rd_en});
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case (op)
      OP_PUSH: cnt_d = cnt_q + CNT_W'(1);
      OP_POP:  cnt_d = cnt_q - CNT_W'(1);
      OP_IDLE,
      OP_BOTH: cnt_d = cnt_q;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  fifo_sync_mem #(
    .DEPTH (NUM_SLOTS),
    .AW    (PTR_W),
    .DW    (DATA_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_write),
    .raddr_i (rd_ptr_q),
    .rdata_c (mem_rdata)
  );

`ifdef FIFO_CHECK_EN
  // Simulation-only misuse reporting with sticky counters
  logic [FIFO_DBG_CNT_W-1:0] overflow_cnt;
  logic [FIFO_DBG_CNT_W-1:0] underflow_cnt;
  logic [31:0]               cycle_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_cnt  <= '0;
      underflow_cnt <= '0;
      cycle_q       <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (write && full) begin
        overflow_cnt <= overflow_cnt + FIFO_DBG_CNT_W'(1);
        $error("fifo_sync overflow at cycle %0d", cycle_q);
      end
      if (next_read && empty) begin
        underflow_cnt <= underflow_cnt + FIFO_DBG_CNT_W'(1);
        $error("fifo_sync underflow at cycle %0d", cycle_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// Directed self-checking bench for fifo_sync (NUM_SLOTS=4, DATA_WIDTH=8).
module tb_fifo_sync;

  logic       clk;
  logic       rst;
  logic [7:0] data_write;
  logic       write;
  logic       full;
  logic       almost_full;
  logic [7:0] data_read;
  logic       next_read;
  logic       empty;

  int n_cmp;
  int n_err;

  fifo_sync #(
    .NUM_SLOTS     (4),
    .LOG_NUM_SLOTS (2),
    .DATA_WIDTH    (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_write  (data_write),
    .write       (write),
    .full        (full),
    .almost_full (almost_full),
    .data_read   (data_read),
    .next_read   (next_read),
    .empty       (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic e, input logic af, input logic f);
    check({tag, ".empty"}, 32'(empty), 32'(e));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(af));
    check({tag, ".full"}, 32'(full), 32'(f));
  endtask

  initial begin
    logic [7:0] seq4 [4];
    logic [7:0] wv;
    logic [7:0] rv;

    n_cmp = 0;
    n_err = 0;
    seq4  = '{8'h11, 8'h22, 8'h33, 8'h44};

    rst        = 1'b0;
    write      = 1'b0;
    next_read  = 1'b0;
    data_write = 8'h00;
    tick();
    tick();
    rst = 1'b1;

    // Reset then idle
    check_flags("rst", 1'b1, 1'b0, 1'b0);
    check("rst.data_read", 32'(data_read), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_flags("idle", 1'b1, 1'b0, 1'b0);
      check("idle.data_read", 32'(data_read), 32'h0);
    end

    // Fill to full, overflow dropped, drain in order
    write = 1'b1;
    data_write = 8'h11; tick();
    check_flags("fill1", 1'b0, 1'b0, 1'b0);
    check("fill1.data_read", 32'(data_read), 32'h11);
    data_write = 8'h22; tick();
    check_flags("fill2", 1'b0, 1'b1, 1'b0);
    data_write = 8'h33; tick();
    check_flags("fill3", 1'b0, 1'b1, 1'b0);
    data_write = 8'h44; tick();
    check_flags("fill4", 1'b0, 1'b1, 1'b1);
    data_write = 8'h55; tick();
    check_flags("ovf", 1'b0, 1'b1, 1'b1);
    check("ovf.data_read", 32'(data_read), 32'h11);
    write = 1'b0;
    next_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain.data_read", 32'(data_read), 32'(seq4[i]));
      tick();
    end
    next_read = 1'b0;
    check_flags("drained", 1'b1, 1'b0, 1'b0);
    check("drained.data_read", 32'(data_read), 32'h0);

    // Single word fall-through
    write = 1'b1; data_write = 8'hA5; tick();
    write = 1'b0;
    check("fwft.data_read", 32'(data_read), 32'hA5);
    check("fwft.empty", 32'(empty), 32'h0);
    next_read = 1'b1; tick();
    next_read = 1'b0;
    check("fwft_pop.empty", 32'(empty), 32'h1);

    // Streaming with occupancy held at 2 while pointers wrap
    write = 1'b1;
    wv = 8'h00;
    rv = 8'h00;
    data_write = wv; tick(); wv++;
    data_write = wv; tick(); wv++;
    next_read = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data_write = wv;
      check("stream.data_read", 32'(data_read), 32'(rv));
      check_flags("stream", 1'b0, 1'b1, 1'b0);
      tick();
      wv++;
      rv++;
    end
    write = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("stream_tail.data_read", 32'(data_read), 32'(rv));
      tick();
      rv++;
    end
    next_read = 1'b0;
    check("stream_end.empty", 32'(empty), 32'h1);

    // Read while empty does not pop a same-cycle write
    write = 1'b1; next_read = 1'b1; data_write = 8'h77; tick();
    next_read = 1'b0;
    check("rd_empty.data_read", 32'(data_read), 32'h77);
    check("rd_empty.empty", 32'(empty), 32'h0);
    data_write = 8'h78; tick();
    data_write = 8'h79; tick();
    data_write = 8'h7A; tick();
    check("full_again.full", 32'(full), 32'h1);

    // Write while full plus pop: pop accepted, write dropped
    data_write = 8'h99; next_read = 1'b1; tick();
    write = 1'b0;
    check_flags("full_pop", 1'b0, 1'b1, 1'b0);
    check("full_pop.data_read", 32'(data_read), 32'h78);
    tick();
    check("full_pop2.data_read", 32'(data_read), 32'h79);
    tick();
    check("full_pop3.data_read", 32'(data_read), 32'h7A);
    tick();
    next_read = 1'b0;
    check("full_pop_end.empty", 32'(empty), 32'h1);
    check("full_pop_end.data_read", 32'(data_read), 32'h0);

    // Mid-operation reset discards contents; inputs ignored during reset
    write = 1'b1;
    data_write = 8'hC1; tick();
    data_write = 8'hC2; tick();
    data_write = 8'hC3; tick();
    check("pre_rst.almost_full", 32'(almost_full), 32'h1);
    rst = 1'b0; data_write = 8'hEE; tick();
    rst = 1'b1; write = 1'b0;
    check_flags("mid_rst", 1'b1, 1'b0, 1'b0);
    check("mid_rst.data_read", 32'(data_read), 32'h0);
    write = 1'b1; data_write = 8'h3C; tick();
    data_write = 8'h3D; next_read = 1'b1;
    check("post_rst.data_read", 32'(data_read), 32'h3C);
    tick();
    write = 1'b0; next_read = 1'b0;
    check("post_rst2.data_read", 32'(data_read), 32'h3D);
    check_flags("post_rst2", 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
